dense_25d_stream: RTL
=====================

# dense_25d_stream

Streaming, parametrised successor to the fixed-pipeline 2.5D dense layer. It accepts one Z_DEPTH-channel pixel vector per valid beat and keeps a per-channel sliding window of WINDOW = P_SR_DEPTH*NUM_SR_ROWS pixels. For every complete window it computes NUM_TREES dot products over window × Z, then adds a per-tree bias and optionally applies ReLU. It sits between the input pixel stream and the next layer or pooling stage. Unlike its predecessor it has valid qualification, window-fill tracking, frame restart, bias/ReLU and a window counter.

## Interface
Parameters:
- NUM_TREES, 2, number of output kernels (trees)
- Z_DEPTH, 2, input channels per pixel vector (power of 2, ≥1)
- P_SR_DEPTH, 4, window columns
- NUM_SR_ROWS, 4, window rows (WINDOW must be a power of 2)
- ACC_W, 32, accumulator/output width per tree

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  pixel_vector_in valid this cycle
- frame_start  in  1  with in_valid: the beat is the first pixel of a new frame
- pixel_vector_in  in  8*Z_DEPTH  unsigned pixels; channel z at [8z+7:8z]
- kernel  in  8*WINDOW*NUM_TREES*Z_DEPTH  signed weights; block (t + NUM_TREES*z) holds WINDOW bytes, element 0 at LSB
- bias  in  ACC_W*NUM_TREES  signed bias per tree
- relu_en  in  1  clamp negative results to 0
- out_valid  out  1  pixel_vector_out valid
- pixel_vector_out  out  ACC_W*NUM_TREES  signed result; tree t at [ACC_W*t+ACC_W-1:ACC_W*t]
- window_count  out  16  windows emitted since reset, wraps

## Operation
- Window: a per-channel shift register of WINDOW bytes. It shifts only on in_valid. Element 0 is the oldest accepted pixel and element WINDOW-1 is the newest.
- Fill counter, 0..WINDOW, saturating:
  - increments on in_valid;
  - in_valid & frame_start loads 1 (the window contents are kept, but the counter forces a full refill before a result is produced);
  - frame_start without in_valid is ignored.
- Window issue: an accepted beat issues a window iff the post-update fill count == WINDOW. The beat that completes the fill issues a window, and so does every following beat.
- Per tree t: sum over z and k of pixel[z][k] (zero-extended 9-bit) × kernel[t][z][k] (signed 8-bit). Products are 17-bit signed, sign-extended into ACC_W.
- Then add bias[t]. If relu_en is set and the result is < 0, output 0. There is no saturation: wrap modulo 2^ACC_W.
- Pipeline: mult register → binary adder tree over WINDOW (CLOG2(WINDOW) registered levels) → Z adder tree (CLOG2(Z_DEPTH) levels, 0 when Z_DEPTH=1) → bias/ReLU register.
- The pipeline advances every cycle, with no backpressure. Bubbles travel as out_valid=0.
- kernel, bias and relu_en are quasi-static. The bench holds them stable while windows are in flight.
- pixel_vector_out holds its last value while out_valid=0.
- window_count increments on each out_valid cycle.

## Timing
- LAT = 2 + CLOG2(WINDOW) + CLOG2(Z_DEPTH) cycles, measured from the edge that accepts the window-completing beat to the edge that raises out_valid. For the defaults, LAT = 7.
- Back-to-back valid beats after fill give out_valid high on consecutive cycles, with results in issue order.
- Reset (sync, high) clears the window to 0, the fill counter, all pipeline valids, pixel_vector_out = 0, out_valid = 0 and window_count = 0. These values are visible after the first clock edge with reset high.
- Reset mid-stream drops all in-flight results: no out_valid for at least WINDOW+LAT cycles after release.
- in_valid during reset is ignored.
- A frame_start beat while windows are in flight still lets those results emerge. No new window issues until WINDOW beats (including the frame_start beat) have been accepted.
- window_count wraps from 0xFFFF to 0x0000.

## Test plan
- Continuity, defaults (Z_DEPTH=2, NUM_TREES=2), bias 0, relu_en 0:
  - stimulus: tree0 kernel all 1, tree1 kernel all 8'hff; both channels receive counter pixels 0,1,2,… one per cycle;
  - first result at 7 cycles after accepting pixel 15: tree0 = 240, tree1 = -240;
  - next cycle: tree0 = 272, tree1 = -272.
- Same stimulus with relu_en = 1 and bias = {tree1: 10, tree0: -250}: first result tree0 = 0, tree1 = 0; second result tree0 = 22, tree1 = 0.
- Bubbles: in_valid toggles 1/0 after fill → out_valid follows the same 1/0 pattern delayed by LAT, with values 240, 272, 304 on successive valid cycles.
- Frame restart: frame_start on beat 20 → results from beats 15..19 emerge; the next result is issued only by beat 35. window_count = 6 after the first 6 results.
- Reset mid-stream at 3 cycles after fill → out_valid = 0 from the next edge, pixel_vector_out = 0, window_count = 0; a fresh window of 16 beats produces 240 again.
- Z_DEPTH = 1, NUM_TREES = 1, kernel all 2, pixels 0..15 → result 240 at LAT = 6.

Source files
------------

// File: rtl/dense_25d_stream.sv
`default_nettype none
// ============================================================================
//  Module   : dense_25d_stream
//  Purpose  : Streaming 2.5D dense layer. Keeps a per-channel sliding window
//             of WINDOW = P_SR_DEPTH*NUM_SR_ROWS pixels and, for every
//             complete window, emits NUM_TREES dot products over window x Z
//             plus a per-tree bias, with optional ReLU.
//  Ports    : clock            rising-edge clock
//             reset            synchronous active-high reset
//             in_valid         pixel_vector_in valid this cycle
//             frame_start      with in_valid: first pixel of a new frame
//             pixel_vector_in  Z_DEPTH unsigned bytes, channel z at [8z+:8]
//             kernel           signed weights, block (t+NUM_TREES*z) holds
//                              WINDOW bytes, element 0 at LSB
//             bias             signed bias per tree, ACC_W bits each
//             relu_en          clamp negative results to 0
//             out_valid        pixel_vector_out valid
//             pixel_vector_out tree t at [ACC_W*t+:ACC_W], held when idle
//             window_count     windows emitted since reset, wraps
//  Revision : 1.0  initial release
// ============================================================================
module dense_25d_stream #(
  parameter int NUM_TREES   = 2,
  parameter int Z_DEPTH     = 2,
  parameter int P_SR_DEPTH  = 4,
  parameter int NUM_SR_ROWS = 4,
  parameter int ACC_W       = 32
) (
  input  logic                                                 clock,
  input  logic                                                 reset,
  input  logic                                                 in_valid,
  input  logic                                                 frame_start,
  input  logic [8*Z_DEPTH-1:0]                                 pixel_vector_in,
  input  logic [8*P_SR_DEPTH*NUM_SR_ROWS*NUM_TREES*Z_DEPTH-1:0] kernel,
  input  logic [ACC_W*NUM_TREES-1:0]                           bias,
  input  logic                                                 relu_en,
  output logic                                                 out_valid,
  output logic [ACC_W*NUM_TREES-1:0]                           pixel_vector_out,
  output logic [15:0]                                          window_count
);

  localparam int c_WINDOW = P_SR_DEPTH * NUM_SR_ROWS;
  localparam int c_LW     = $clog2(c_WINDOW);
  localparam int c_LZ     = $clog2(Z_DEPTH);
  localparam int c_NL     = Z_DEPTH * c_WINDOW;    // adder-tree leaves per tree
  localparam int c_DEPTH  = 1 + c_LW + c_LZ;       // issue flag .. tree root
  localparam int c_FW     = $clog2(c_WINDOW + 1);

  // 9-bit zero-extended pixel times 8-bit signed weight, sign-extended.
  function automatic logic [ACC_W-1:0] f_mul(input logic [7:0] i_pix,
                                             input logic [7:0] i_wt);
    logic [16:0] w_a;
    logic [16:0] w_b;
    logic [16:0] w_prod;
    w_a    = {9'b0, i_pix};
    w_b    = {{9{i_wt[7]}}, i_wt};
    w_prod = w_a * w_b;
    return {{(ACC_W-17){w_prod[16]}}, w_prod};
  endfunction

  logic [7:0]             r_win [Z_DEPTH][c_WINDOW];
  logic [c_FW-1:0]        r_fill;
  logic [c_FW-1:0]        w_fill_next;
  logic                   w_issue;
  logic [c_DEPTH:0]       r_pv;       // bit 0: issue flag, bit c_DEPTH: root valid
  logic [ACC_W-1:0]       r_node [NUM_TREES][1:2*c_NL-1];
  logic [ACC_W*NUM_TREES-1:0] w_res;
  logic [ACC_W*NUM_TREES-1:0] r_out;
  logic                   r_ovalid;
  logic [15:0]            r_wcnt;

  // Fill tracking: a frame_start beat reloads 1 so a full refill is needed.
  always_comb begin
    w_fill_next = r_fill;
    if (in_valid) begin
      if (frame_start)
        w_fill_next = c_FW'(1);
      else if (r_fill != c_FW'(c_WINDOW))
        w_fill_next = r_fill + 1'b1;
    end
  end

  assign w_issue = in_valid && (w_fill_next == c_FW'(c_WINDOW));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int z = 0; z < Z_DEPTH; z++)
        for (int k = 0; k < c_WINDOW; k++)
          r_win[z][k] <= 8'd0;
      r_fill   <= '0;
      r_pv     <= '0;
      r_out    <= '0;
      r_ovalid <= 1'b0;
      r_wcnt   <= 16'd0;
    end else begin
      if (in_valid) begin
        for (int z = 0; z < Z_DEPTH; z++) begin
          for (int k = 0; k < c_WINDOW - 1; k++)
            r_win[z][k] <= r_win[z][k+1];
          r_win[z][c_WINDOW-1] <= pixel_vector_in[8*z +: 8];
        end
      end
      r_fill   <= w_fill_next;
      r_pv     <= {r_pv[c_DEPTH-1:0], w_issue};
      r_ovalid <= r_pv[c_DEPTH];
      if (r_pv[c_DEPTH]) begin
        r_out  <= w_res;
        r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end

  // One heap-ordered adder tree per tree t. Leaves are laid out channel-major
  // (WINDOW contiguous leaves per channel), so the lower c_LW levels reduce
  // each channel's window and the upper c_LZ levels reduce across channels.
  // Every node is a register, giving one cycle per level.
  always_ff @(posedge clock) begin
    for (int t = 0; t < NUM_TREES; t++) begin
      for (int z = 0; z < Z_DEPTH; z++)
        for (int k = 0; k < c_WINDOW; k++)
          r_node[t][c_NL + z*c_WINDOW + k] <=
            f_mul(r_win[z][k], kernel[8*((t + NUM_TREES*z)*c_WINDOW + k) +: 8]);
      for (int i = 1; i < c_NL; i++)
        r_node[t][i] <= r_node[t][2*i] + r_node[t][2*i+1];
    end
  end

  for (genvar gt = 0; gt < NUM_TREES; gt++) begin : g_out
    logic [ACC_W-1:0] w_sum;
    assign w_sum = r_node[gt][1] + bias[ACC_W*gt +: ACC_W];
    assign w_res[ACC_W*gt +: ACC_W] = (relu_en && w_sum[ACC_W-1]) ? '0 : w_sum;
  end

  assign out_valid        = r_ovalid;
  assign pixel_vector_out = r_out;
  assign window_count     = r_wcnt;

endmodule
`default_nettype wire
